// File: rtl/dram_wr_drain.sv
`default_nettype none
// ============================================================================
// dram_wr_drain: stages BURST_LEN words popped from the DRAM write buffer, then
// runs a req/ack-granted write burst with an incrementing word address.
// Optional partial-burst flush: define DRAM_WR_DRAIN_FLUSH_EN.
// Revision: 1.0
// ============================================================================
module dram_wr_drain #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [WIDTH-1:0]  fifo_dataout,
  input  logic              fifo_empty,
  input  logic              fifo_rd_valid,
  output logic              fifo_rd_en,
  output logic              burst_req,
  input  logic              burst_ack,
  output logic [ADDR_W-1:0] burst_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              wr_valid,
  output logic              wr_last,
  output logic              busy
`ifdef DRAM_WR_DRAIN_FLUSH_EN
  ,
  input  logic                           flush,
  output logic [$clog2(BURST_LEN+1)-1:0] burst_len
`endif
);

  localparam int            CW   = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] FULL = CW'(BURST_LEN);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_REQ     = 2'd1,
    S_SEND    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     beat_q, beat_d;
  logic              pend_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              wv_q, wv_d;
  logic              wl_q, wl_d;
  logic [WIDTH-1:0]  wd_q, wd_d;
  logic [WIDTH-1:0]  stage_q [BURST_LEN];

  logic              stage_we;
  logic [WIDTH-1:0]  beat_word;
  logic [CW:0]       inflight;
  logic              flush_go;
  logic              hold_rd;
  logic              rd_en;

`ifdef DRAM_WR_DRAIN_FLUSH_EN
  assign flush_go  = flush && (cnt_q != '0) && !pend_q;
  assign hold_rd   = flush;
  assign burst_len = req_q ? cnt_q : '0;
`else
  assign flush_go  = 1'b0;
  assign hold_rd   = 1'b0;
`endif

  // A word is only staged when it answers a read issued last cycle.
  assign stage_we = fifo_rd_valid && pend_q && (state_q == S_COLLECT);
  assign inflight = {1'b0, cnt_q} + {{CW{1'b0}}, pend_q};

  always_comb begin
    beat_word = '0;
    for (int i = 0; i < BURST_LEN; i++) begin
      if (beat_q == CW'(i)) beat_word = stage_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    req_d   = req_q;
    wv_d    = 1'b0;
    wl_d    = 1'b0;
    wd_d    = '0;
    rd_en   = 1'b0;
    case (state_q)
      S_COLLECT: begin
        rd_en = !fifo_empty && !hold_rd && (inflight < {1'b0, FULL});
        if (stage_we) cnt_d = cnt_q + CW'(1);
        if (!pend_q && ((cnt_q == FULL) || flush_go)) begin
          state_d = S_REQ;
          req_d   = 1'b1;
        end
      end
      S_REQ: begin
        if (burst_ack) begin
          state_d = S_SEND;
          req_d   = 1'b0;
          wv_d    = 1'b1;
          wd_d    = beat_word;
          wl_d    = (cnt_q == CW'(1));
          beat_d  = CW'(1);
        end
      end
      S_SEND: begin
        // cnt_q holds the burst length for the whole of REQ and SEND.
        if (wl_q) begin
          state_d = S_COLLECT;
          cnt_d   = '0;
          beat_d  = '0;
          addr_d  = addr_q + ADDR_W'(cnt_q);
        end else begin
          wv_d   = 1'b1;
          wd_d   = beat_word;
          wl_d   = (beat_q == cnt_q - CW'(1));
          beat_d = beat_q + CW'(1);
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
      beat_q  <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      wv_q    <= 1'b0;
      wl_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      pend_q  <= fifo_rd_en;
      addr_q  <= addr_d;
      req_q   <= req_d;
      wv_q    <= wv_d;
      wl_q    <= wl_d;
      wd_q    <= wd_d;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < BURST_LEN; i++) stage_q[i] <= '0;
    end else if (stage_we) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        if (cnt_q == CW'(i)) stage_q[i] <= fifo_dataout;
      end
    end
  end

  // Read request is held off while reset is asserted so every output reads 0.
  assign fifo_rd_en = rd_en & rst_b;
  assign burst_req  = req_q;
  assign burst_addr = addr_q;
  assign wr_data    = wd_q;
  assign wr_valid   = wv_q;
  assign wr_last    = wl_q;
  assign busy       = !((state_q == S_COLLECT) && (cnt_q == '0));

endmodule
`default_nettype wire
